hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised next-generation hazard unit for the 5-stage core (IF/ID/EX/MEM/WB). Produces
//  per-operand forwarding selects for EX and a stall request for ID. A per-register latency
//  scoreboard covers load-use, multi-cycle (mul/div) RAW, WAW ordering and a non-pipelined
//  long-op unit. Sits between the ID/EX pipeline registers and the EX operand muxes.
// PARAMETERS
//  NREG     32  architectural registers; x0 hard-wired zero
//  AW       5   register index width, $clog2(NREG)
//  NRS      2   source operands per instruction
//  NSRC     2   forwarding sources; index 0 = youngest (EX/MEM), NSRC-1 = oldest (MEM/WB)
//  MAX_LAT  7   largest result latency in cycles after issue
//  LW       3   counter width, $clog2(MAX_LAT+1)
//  SW       2   select width, $clog2(NSRC+1)
// PORTS
//  clk          in   1          rising-edge clock
//  rst_n        in   1          asynchronous active-low reset
//  id_valid     in   1          valid instruction in ID
//  id_rs        in   NRS*AW     ID source indices, operand k at [k*AW +: AW]
//  id_rs_used   in   NRS        operand k actually read
//  id_rd        in   AW         ID destination
//  id_wr        in   1          ID instruction writes id_rd
//  id_lat       in   LW         cycles after issue until result is forwardable (ALU 0, load 1, mul/div >=2)
//  flush        in   1          pipeline flush (branch/trap)
//  ex_rs        in   NRS*AW     EX-stage source indices
//  src_wr       in   NSRC       forwarding source i writes a register
//  src_rd       in   NSRC*AW    forwarding source i destination, [i*AW +: AW]
//  stall        out  1          hold PC and IF/ID, insert bubble in ID/EX
//  issue        out  1          id_valid & ~stall & ~flush
//  fwd_sel      out  NRS*SW     operand k select: 0 = regfile, NSRC-i = source i
//  stall_cycles out  32         saturating count of cycles with stall=1
// BEHAVIOUR
//  - Reset (rst_n=0, async): all cnt[r]=0, lu_cnt=0, stall_cycles=0. stall=0 and issue=0 while
//    id_valid=0. fwd_sel is combinational, so all-zero inputs give 0.
//  - Forwarding is combinational, zero latency. For each k, the lowest i with src_wr[i],
//    src_rd[i]==ex_rs[k] and src_rd[i]!=0 wins: fwd_sel[k]=NSRC-i. No match gives 0.
//    With NSRC=2 this is 2=EX/MEM and 1=MEM/WB.
//  - Scoreboard: cnt[r] is LW bits per register.
//    - Every cycle, each nonzero cnt is decremented by 1.
//    - On issue with id_wr and id_rd!=0, cnt[id_rd] <= id_lat. This set beats the decrement of
//      the same register in that cycle.
//    - cnt[0] is always 0.
//  - Stall (combinational) = id_valid & ~flush & (RAW | WAW | STRUCT):
//    - RAW: any k with id_rs_used[k] and cnt[id_rs[k]]!=0.
//    - WAW: id_wr and cnt[id_rd] > id_lat (older long op still outstanding on the same rd).
//    - STRUCT: id_lat>=2 and lu_cnt!=0.
//  - Long-op unit: on issue with id_lat>=2, lu_cnt <= id_lat-1. Otherwise lu_cnt decrements
//    to 0.
//  - Flush: synchronously clears all cnt and lu_cnt, forces issue=0, and forces stall=0 in the
//    same cycle. Flush outranks every other update.
//  - stall_cycles increments when stall=1 and holds at 32'hFFFF_FFFF.
//  - Boundaries:
//    - id_lat=0 never stalls a successor.
//    - id_lat=MAX_LAT stalls a dependent for exactly MAX_LAT cycles.
//    - rd=0 never creates a stall or a forward.
//    - Same register on both operands counts once.
//    - Reset asserted mid-operation clears everything immediately.
// STRUCTURE
//  - Package cpu_hazard_pkg: FWD_RF=0 and the select encoding; default LAT_ALU=0, LAT_LOAD=1,
//    LAT_MUL=3, LAT_DIV=7.
//  - Sub-module fwd_select (one per operand, via generate): priority match of one ex_rs
//    against NSRC sources.
//  - Top level holds the counter array, lu_cnt, the stall logic and the perf counter.
// TESTING
//  - ALU chain: add x5 then add x6,x5 (lat 0) -> stall=0 throughout; second op in EX sees
//    fwd_sel[0]=2. Two cycles later with x5 only in MEM/WB -> fwd_sel=1.
//  - Load-use: lw x5 (lat 1) then add x7,x5,x1 -> stall=1 for exactly 1 cycle, then issue=1;
//    stall_cycles=1.
//  - Mul RAW, WAW and STRUCT:
//    - mul x8 (lat 3), then use x8 -> 3 stall cycles.
//    - mul x8 then add x8 (lat 0) -> WAW stall until cnt[x8]==0.
//    - Two back-to-back div (lat 7) -> second waits 6 cycles.
//  - Priority and x0:
//    - EX/MEM and MEM/WB both write x9, ex_rs=9 -> fwd_sel=2.
//    - src_rd=0 with src_wr=1, ex_rs=0 -> fwd_sel=0.
//    - lw x0 then use x0 -> no stall.
//  - Flush and reset: div x4 issued, flush at cycle 2 -> next cycle cnt[x4]=0 and a use of x4
//    issues with no stall. Pulse rst_n low mid-stall -> stall_cycles=0 and stall=0 immediately.
//  - Saturation: preload stall_cycles near 32'hFFFF_FFFF (force) with stall held -> value
//    holds at all-ones.

Source files
------------

// File: rtl/cpu_hazard_pkg.sv
// ============================================================================
// Module      : cpu_hazard_pkg
// Description : Shared constants for the hazard scoreboard: forwarding select
//               encoding and default result latencies per operation class.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_hazard_pkg;

   localparam int FWD_RF       = 0;
   localparam int FWD_MEMWB    = 1;
   localparam int FWD_EXMEM    = 2;

   localparam int LAT_ALU      = 0;
   localparam int LAT_LOAD     = 1;
   localparam int LAT_MUL      = 3;
   localparam int LAT_DIV      = 7;

   // Latencies at or above this occupy the non-pipelined long-op unit
   localparam int LAT_LONG_MIN = 2;

   function automatic int fwd_code(input int nsrc, input int src_idx);
      return nsrc - src_idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_select.sv
// ============================================================================
// Module      : fwd_select
// Description : Priority match of one EX source index against the forwarding
//               sources; the youngest matching writer wins, x0 never matches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_select
   import cpu_hazard_pkg::*;
#(
   parameter int AW   = 5,
   parameter int NSRC = 2,
   parameter int SW   = 2
) (
   input  logic [AW-1:0]      rs,
   input  logic [NSRC-1:0]    src_wr,
   input  logic [NSRC*AW-1:0] src_rd,
   output logic [SW-1:0]      sel
);

   always_comb begin
      sel = SW'(FWD_RF);
      // Walk oldest to youngest so the lowest index is written last
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (src_wr[i] && (src_rd[i*AW +: AW] == rs) && (src_rd[i*AW +: AW] != '0)) begin
            sel = SW'(fwd_code(NSRC, i));
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : Per-register latency scoreboard producing EX forwarding
//               selects, the ID stall request and a stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
   import cpu_hazard_pkg::*;
#(
   parameter int NREG    = 32,
   parameter int AW      = 5,
   parameter int NRS     = 2,
   parameter int NSRC    = 2,
   parameter int MAX_LAT = 7,
   parameter int LW      = 3,
   parameter int SW      = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [NRS*AW-1:0]  id_rs,
   input  logic [NRS-1:0]     id_rs_used,
   input  logic [AW-1:0]      id_rd,
   input  logic               id_wr,
   input  logic [LW-1:0]      id_lat,
   input  logic               flush,
   input  logic [NRS*AW-1:0]  ex_rs,
   input  logic [NSRC-1:0]    src_wr,
   input  logic [NSRC*AW-1:0] src_rd,
   output logic               stall,
   output logic               issue,
   output logic [NRS*SW-1:0]  fwd_sel,
   output logic [31:0]        stall_cycles
);

   logic [LW-1:0] cnt [NREG];
   logic [LW-1:0] lu_cnt;
   logic [LW-1:0] lat_eff;
   logic          raw_hz;
   logic          waw_hz;
   logic          struct_hz;
   logic          long_op;
   logic          set_rd;

   genvar k;
   generate
      for (k = 0; k < NRS; k++) begin : g_fwd
         fwd_select #(
            .AW   (AW),
            .NSRC (NSRC),
            .SW   (SW)
         ) u_fwd_select (
            .rs     (ex_rs[k*AW +: AW]),
            .src_wr (src_wr),
            .src_rd (src_rd),
            .sel    (fwd_sel[k*SW +: SW])
         );
      end
   endgenerate

   always_comb begin
      lat_eff = id_lat;
      if (32'(id_lat) > MAX_LAT) begin
         lat_eff = LW'(MAX_LAT);
      end

      raw_hz = 1'b0;
      for (int i = 0; i < NRS; i++) begin
         if (id_rs_used[i] && (cnt[id_rs[i*AW +: AW]] != '0)) begin
            raw_hz = 1'b1;
         end
      end

      // A younger, faster write must not land before an older long op on the same rd
      waw_hz    = id_wr && (cnt[id_rd] > lat_eff);
      long_op   = (lat_eff >= LW'(LAT_LONG_MIN));
      struct_hz = long_op && (lu_cnt != '0);

      stall  = id_valid && !flush && (raw_hz || waw_hz || struct_hz);
      issue  = id_valid && !stall && !flush;
      set_rd = issue && id_wr && (id_rd != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            cnt[r] <= '0;
         end
      end else if (flush) begin
         for (int r = 0; r < NREG; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (r == 0) begin
               cnt[r] <= '0;
            end else if (set_rd && (id_rd == AW'(r))) begin
               cnt[r] <= lat_eff;
            end else if (cnt[r] != '0) begin
               cnt[r] <= cnt[r] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lu_cnt <= '0;
      end else if (flush) begin
         lu_cnt <= '0;
      end else if (issue && long_op) begin
         lu_cnt <= lat_eff - 1'b1;
      end else if (lu_cnt != '0) begin
         lu_cnt <= lu_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed scenarios plus randomized traffic checked every cycle
//               against a cycle-timestamp model of the hazard rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

   localparam int NREG    = 32;
   localparam int AW      = 5;
   localparam int NRS     = 2;
   localparam int NSRC    = 2;
   localparam int MAX_LAT = 7;
   localparam int LW      = 3;
   localparam int SW      = 2;

   logic               clk        = 1'b0;
   logic               rst_n      = 1'b0;
   logic               id_valid   = 1'b0;
   logic [NRS*AW-1:0]  id_rs      = '0;
   logic [NRS-1:0]     id_rs_used = '0;
   logic [AW-1:0]      id_rd      = '0;
   logic               id_wr      = 1'b0;
   logic [LW-1:0]      id_lat     = '0;
   logic               flush      = 1'b0;
   logic [NRS*AW-1:0]  ex_rs      = '0;
   logic [NSRC-1:0]    src_wr     = '0;
   logic [NSRC*AW-1:0] src_rd     = '0;
   logic               stall;
   logic               issue;
   logic [NRS*SW-1:0]  fwd_sel;
   logic [31:0]        stall_cycles;

   int checks = 0;
   int errors = 0;

   hazard_scoreboard #(
      .NREG(NREG), .AW(AW), .NRS(NRS), .NSRC(NSRC),
      .MAX_LAT(MAX_LAT), .LW(LW), .SW(SW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rs_used   (id_rs_used),
      .id_rd        (id_rd),
      .id_wr        (id_wr),
      .id_lat       (id_lat),
      .flush        (flush),
      .ex_rs        (ex_rs),
      .src_wr       (src_wr),
      .src_rd       (src_rd),
      .stall        (stall),
      .issue        (issue),
      .fwd_sel      (fwd_sel),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each register remembers the absolute cycle its result becomes forwardable
   longint      now_c = 0;
   longint      ready [NREG];
   longint      lu_free = 0;
   logic [31:0] m_sc = '0;
   bit          m_raw, m_waw, m_st, m_stall, m_issue;
   int          m_lat, m_rd;

   function automatic int rem(input int r);
      return (ready[r] > now_c) ? int'(ready[r] - now_c) : 0;
   endfunction

   function automatic int m_fwd(input int k);
      int exr = int'(ex_rs[k*AW +: AW]);
      for (int i = 0; i < NSRC; i++) begin
         int sr = int'(src_rd[i*AW +: AW]);
         if (src_wr[i] && sr == exr && sr != 0) return NSRC - i;
      end
      return 0;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) ready[r] = 0;
         lu_free = 0;
         m_sc    = '0;
         now_c   = 0;
      end
      m_lat = int'(id_lat);
      m_rd  = int'(id_rd);
      m_raw = 1'b0;
      for (int k = 0; k < NRS; k++)
         if (id_rs_used[k] && rem(int'(id_rs[k*AW +: AW])) != 0) m_raw = 1'b1;
      m_waw   = id_wr && (rem(m_rd) > m_lat);
      m_st    = (m_lat >= 2) && (lu_free > now_c);
      m_stall = id_valid && !flush && (m_raw || m_waw || m_st);
      m_issue = id_valid && !flush && !m_stall;

      chk("stall", 32'(stall), 32'(m_stall));
      chk("issue", 32'(issue), 32'(m_issue));
      for (int k = 0; k < NRS; k++) chk("fwd_sel", 32'(fwd_sel[k*SW +: SW]), 32'(m_fwd(k)));
      chk("stall_cycles", stall_cycles, m_sc);

      if (rst_n) begin
         if (flush) begin
            for (int r = 0; r < NREG; r++) ready[r] = 0;
            lu_free = 0;
         end else if (m_issue) begin
            if (id_wr && m_rd != 0) ready[m_rd] = now_c + 1 + m_lat;
            if (m_lat >= 2) lu_free = now_c + m_lat;
         end
         if (m_stall && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
         now_c++;
      end
   end

   task automatic drive(input bit v, input int rs1, input int rs2, input bit [1:0] used,
                        input int rd, input bit wr, input int lat, input bit fl = 1'b0);
      @(posedge clk);
      #1;
      id_valid   = v;
      id_rs      = {AW'(rs2), AW'(rs1)};
      id_rs_used = used;
      id_rd      = AW'(rd);
      id_wr      = wr;
      id_lat     = LW'(lat);
      flush      = fl;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0, 2'b00, 0, 0, 0);
   endtask

   // Holds the instruction currently in ID until it issues, counting stall cycles
   task automatic wait_issue(input string name, input int exp);
      int stalls = 0;
      bit done   = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         #2;
         if (issue) done = 1'b1;
         else begin
            if (stall) stalls++;
            @(posedge clk);
            #1;
         end
      end
      chk({name, "_timeout"}, 32'(done), 32'd1);
      chk(name, stalls, exp);
   endtask

   initial begin
      @(posedge clk);
      #1;
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_issue", 32'(issue), 32'd0);
      chk("reset_fwd", 32'(fwd_sel), 32'd0);
      chk("reset_stall_cycles", stall_cycles, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // ALU chain
      drive(1, 0, 0, 2'b00, 5, 1, 0);
      #2 chk("alu1_issue", 32'(issue), 32'd1);
      drive(1, 5, 0, 2'b01, 6, 1, 0);
      #2 chk("alu2_stall", 32'(stall), 32'd0);
      chk("alu2_issue", 32'(issue), 32'd1);
      ex_rs = {AW'(0), AW'(5)}; src_wr = 2'b01; src_rd = {AW'(0), AW'(5)};
      #1 chk("alu_fwd_exmem", 32'(fwd_sel[1:0]), 32'd2);
      src_wr = 2'b10; src_rd = {AW'(5), AW'(0)};
      #1 chk("alu_fwd_memwb", 32'(fwd_sel[1:0]), 32'd1);

      // Load-use
      drive(1, 0, 0, 2'b00, 5, 1, 1);
      #2 chk("lw_issue", 32'(issue), 32'd1);
      drive(1, 5, 1, 2'b11, 7, 1, 0);
      wait_issue("load_use_stalls", 1);
      chk("load_use_stall_cycles", stall_cycles, 32'd1);

      idle(8);
      drive(1, 0, 0, 2'b00, 8, 1, 3);
      drive(1, 8, 0, 2'b01, 9, 1, 0);
      wait_issue("mul_raw_stalls", 3);

      idle(8);
      drive(1, 0, 0, 2'b00, 8, 1, 3);
      drive(1, 1, 2, 2'b11, 8, 1, 0);
      wait_issue("waw_stalls", 3);

      idle(8);
      drive(1, 0, 0, 2'b00, 10, 1, 7);
      drive(1, 0, 0, 2'b00, 11, 1, 7);
      wait_issue("div_struct_stalls", 6);

      idle(10);
      drive(1, 0, 0, 2'b00, 12, 1, 7);
      drive(1, 12, 0, 2'b01, 13, 1, 0);
      wait_issue("max_lat_stalls", 7);

      // Priority and x0
      idle(8);
      ex_rs = {AW'(0), AW'(9)}; src_wr = 2'b11; src_rd = {AW'(9), AW'(9)};
      #1 chk("prio_both_x9", 32'(fwd_sel[1:0]), 32'd2);
      ex_rs = {AW'(9), AW'(0)}; src_wr = 2'b01; src_rd = {AW'(9), AW'(0)};
      #1 chk("x0_no_fwd", 32'(fwd_sel[1:0]), 32'd0);
      src_wr = 2'b10;
      #1 chk("op1_fwd_memwb", 32'(fwd_sel[3:2]), 32'd1);
      drive(1, 0, 0, 2'b00, 0, 1, 1);
      drive(1, 0, 0, 2'b11, 3, 1, 0);
      #2 chk("x0_use_stall", 32'(stall), 32'd0);
      chk("x0_use_issue", 32'(issue), 32'd1);
      idle(2);
      drive(1, 0, 0, 2'b00, 5, 1, 1);
      drive(1, 5, 5, 2'b11, 6, 1, 0);
      wait_issue("same_reg_stalls", 1);

      // Flush
      idle(4);
      drive(1, 0, 0, 2'b00, 4, 1, 7);
      idle(1);
      drive(1, 4, 0, 2'b01, 20, 1, 0, 1'b1);
      #2 chk("flush_stall", 32'(stall), 32'd0);
      chk("flush_issue", 32'(issue), 32'd0);
      drive(1, 4, 0, 2'b01, 20, 1, 0);
      #2 chk("post_flush_stall", 32'(stall), 32'd0);
      chk("post_flush_issue", 32'(issue), 32'd1);

      // Reset mid-stall
      idle(2);
      drive(1, 0, 0, 2'b00, 13, 1, 7);
      drive(1, 13, 0, 2'b01, 14, 1, 0);
      #2 chk("pre_reset_stall", 32'(stall), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_stall", 32'(stall), 32'd0);
      chk("async_reset_stall_cycles", stall_cycles, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Saturation
      idle(2);
      drive(1, 0, 0, 2'b00, 14, 1, 7);
      drive(1, 14, 0, 2'b01, 15, 1, 0);
      #1 force dut.stall_cycles = 32'hFFFF_FFFE;
      m_sc = 32'hFFFF_FFFE;
      #1 release dut.stall_cycles;
      @(posedge clk);
      #3 chk("sat_reach", stall_cycles, 32'hFFFF_FFFF);
      @(posedge clk);
      #3 chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);
      idle(10);

      // Randomized traffic; a stalled instruction is usually held in ID
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         rst_n = (n % 1000 == 999) ? 1'b0 : 1'b1;
         if (!(stall && $urandom_range(0, 3) != 0)) begin
            id_valid   = ($urandom_range(0, 9) != 0);
            id_rs      = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            id_rs_used = NRS'($urandom);
            id_rd      = AW'($urandom_range(0, 7));
            id_wr      = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 5))
               0, 1:    id_lat = LW'(0);
               2:       id_lat = LW'(1);
               3:       id_lat = LW'(2);
               4:       id_lat = LW'(3);
               default: id_lat = LW'(7);
            endcase
         end
         flush  = ($urandom_range(0, 29) == 0);
         ex_rs  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
         src_wr = NSRC'($urandom);
         src_rd = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
